ptcalc_mul_arb: RTL and testbench
=================================

PTCALC_MUL_ARB -- requirements
Module: ptcalc_mul_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 Parameter MUL_LAT, default 3, accept-to-result latency in cycles (1..6).
REQ-003 Parameter A_W, default 21, signed multiplicand width.
REQ-004 Parameter B_W, default 12, signed multiplier width; product width P_W = A_W+B_W (33).
REQ-005 ap_clk  in  1  sole clock, all state updates on rising edge.
REQ-006 ap_rst  in  1  reset, synchronous, active-high.
REQ-007 arb_en  in  1  grant enable; 0 blocks new grants, in-flight products still drain.
REQ-008 req_valid  in  N_REQ  per-requester operand valid.
REQ-009 req_ready  out  N_REQ  per-requester grant, one-hot or zero.
REQ-010 req_a  in  N_REQ*A_W  packed signed multiplicands, requester i at [i*A_W +: A_W].
REQ-011 req_b  in  N_REQ*B_W  packed signed multipliers, same packing.
REQ-012 res_valid  out  1  product valid, single-cycle pulse per accepted request.
REQ-013 res_data  out  P_W  signed product.
REQ-014 res_id  out  clog2(N_REQ)  index of the requester that owns res_data.
REQ-015 inflight  out  clog2(MUL_LAT+1)  accepted operations not yet returned.
REQ-016 conflict_cnt  out  16  saturating count of cycles with more than one req_valid high while arb_en=1.

Function
REQ-017 Grant: req_ready[i] = arb_en & req_valid[i] & (i is first valid index at or after rr_ptr, circular); combinational from inputs and rr_ptr.
REQ-018 Accept = req_valid[i] & req_ready[i]; at most one accept per cycle; results are never back-pressured.
REQ-019 On accept of i, rr_ptr <= (i+1) mod N_REQ; otherwise rr_ptr holds.
REQ-020 Accepted operands are registered at the accept edge; requester may change operands the following cycle.
REQ-021 Product = full-precision signed A_W x B_W multiply, no truncation or rounding; (-2^20)*(-2^11) = +2^31 is exact.
REQ-022 An accept at edge k produces res_valid=1 in the cycle following edge k+MUL_LAT-1 (i.e. MUL_LAT cycles after the accept cycle), with matching res_id and res_data.
REQ-023 Pipeline carries valid and id alongside data; back-to-back accepts yield back-to-back results in accept order.
REQ-024 Outside result pulses res_data and res_id hold their last values; res_valid=0.
REQ-025 inflight increments on accept, decrements on res_valid, unchanged when both occur; never exceeds MUL_LAT.
REQ-026 conflict_cnt saturates at 16'hFFFF and does not wrap.
REQ-027 arb_en deassertion does not drop or corrupt in-flight operations.
REQ-028 Requester deasserting req_valid without acceptance is legal; no state changes.

Reset
REQ-029 While ap_rst=1: req_ready=0, rr_ptr=0, all pipeline valid bits 0, res_valid=0, res_data=0, res_id=0, inflight=0, conflict_cnt=0.
REQ-030 Reset during in-flight operations discards them; no res_valid pulse after reset release for pre-reset accepts.
REQ-031 First grant possible in the first cycle after ap_rst deasserts.

Structure
REQ-032 A_W, B_W, P_W defaults and the id-width function belong in the shared ptcalc package.
REQ-033 The multiply is in one sub-module, ptcalc_mul_pipe (signed A_W x B_W, MUL_LAT register stages, valid/id sideband), mappable to a single DSP48 cascade; arbiter, counters in the top.

Verification
REQ-034 Single request: req 2 valid, a=1000, b=-3 -> req_ready[2]=1 that cycle; res_valid, res_id=2, res_data=-3000 exactly 3 cycles later; inflight 1 then 0.
REQ-035 All 4 valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; 8 consecutive results, ids in same order; conflict_cnt=8.
REQ-036 Extremes: a=-2^20, b=-2^11 -> res_data=2^31; a=2^20-1, b=-2^11 -> -(2^31-2^11).
REQ-037 arb_en dropped after 2 accepts -> req_ready=0, both results still emerge, inflight drains to 0.
REQ-038 ap_rst asserted one cycle after 3 back-to-back accepts -> no res_valid after release, all outputs at reset values, next grant to requester 0.
REQ-039 conflict_cnt preloaded near saturation via 65540 contended cycles -> holds 16'hFFFF.

Source files
------------

// File: rtl/ptcalc_pkg.sv
// Shared definitions for the ptcalc arithmetic blocks: default operand
// widths and the index-width helper used for id and counter buses.
package ptcalc_pkg;

  localparam int A_W_DEF = 21;
  localparam int B_W_DEF = 12;
  localparam int P_W_DEF = A_W_DEF + B_W_DEF;

  // Width needed to index n items; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptcalc_mul_pipe.sv
// Signed A_W x B_W multiplier with LAT register stages and a valid/id
// sideband. Operands are captured on the accept edge, the product is formed
// between the operand and first product register, and the last stage only
// updates on valid so the outputs hold their value between results.
module ptcalc_mul_pipe
  import ptcalc_pkg::*;
#(
  parameter int LAT  = 3,
  parameter int A_W  = A_W_DEF,
  parameter int B_W  = B_W_DEF,
  parameter int ID_W = 2,
  localparam int P_W = A_W + B_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [ID_W-1:0]       i_id,
  input  logic signed [A_W-1:0] i_a,
  input  logic signed [B_W-1:0] i_b,
  output logic                  o_valid,
  output logic [ID_W-1:0]       o_id,
  output logic signed [P_W-1:0] o_data
);

  generate
    if (LAT == 1) begin : g_lat1
      logic signed [P_W-1:0] w_prod;
      logic                  r_v;
      logic [ID_W-1:0]       r_id;
      logic signed [P_W-1:0] r_p;

      assign w_prod = P_W'(i_a) * P_W'(i_b);

      // Single stage: register the product directly on the accept edge.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_v  <= 1'b0;
          r_id <= '0;
          r_p  <= '0;
        end else begin
          r_v <= i_valid;
          if (i_valid) begin
            r_id <= i_id;
            r_p  <= w_prod;
          end
        end
      end

      assign o_valid = r_v;
      assign o_id    = r_id;
      assign o_data  = r_p;
    end else begin : g_latn
      logic signed [A_W-1:0] r_a;
      logic signed [B_W-1:0] r_b;
      logic                  r_v0;
      logic [ID_W-1:0]       r_id0;
      logic signed [P_W-1:0] w_prod;
      logic                  r_v  [1:LAT-1];
      logic [ID_W-1:0]       r_id [1:LAT-1];
      logic signed [P_W-1:0] r_p  [1:LAT-1];

      assign w_prod = P_W'(r_a) * P_W'(r_b);

      // Operand capture stage (DSP input registers).
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_v0  <= 1'b0;
          r_id0 <= '0;
          r_a   <= '0;
          r_b   <= '0;
        end else begin
          r_v0 <= i_valid;
          if (i_valid) begin
            r_id0 <= i_id;
            r_a   <= i_a;
            r_b   <= i_b;
          end
        end
      end

      // Product stages; data and id advance only behind a valid bit.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int s = 1; s < LAT; s++) begin
            r_v[s]  <= 1'b0;
            r_id[s] <= '0;
            r_p[s]  <= '0;
          end
        end else begin
          r_v[1] <= r_v0;
          if (r_v0) begin
            r_id[1] <= r_id0;
            r_p[1]  <= w_prod;
          end
          for (int s = 2; s < LAT; s++) begin
            r_v[s] <= r_v[s-1];
            if (r_v[s-1]) begin
              r_id[s] <= r_id[s-1];
              r_p[s]  <= r_p[s-1];
            end
          end
        end
      end

      assign o_valid = r_v[LAT-1];
      assign o_id    = r_id[LAT-1];
      assign o_data  = r_p[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/ptcalc_mul_arb.sv
// Round-robin arbiter sharing one pipelined signed multiplier among N_REQ
// requesters. Tracks operations in flight and counts contended cycles.
module ptcalc_mul_arb
  import ptcalc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 3,
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  localparam int P_W    = A_W + B_W,
  localparam int ID_W   = id_width(N_REQ),
  localparam int CNT_W  = id_width(MUL_LAT + 1)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   arb_en,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*B_W-1:0]   req_b,
  output logic                   res_valid,
  output logic [P_W-1:0]         res_data,
  output logic [ID_W-1:0]        res_id,
  output logic [CNT_W-1:0]       inflight,
  output logic [15:0]            conflict_cnt
);

  logic [ID_W-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]      r_inflight;
  logic [15:0]           r_conflict;
  logic                  w_gnt_found;
  logic [ID_W-1:0]       w_gnt_idx;
  logic [N_REQ-1:0]      w_req_ready;
  logic                  w_accept;
  logic                  w_multi;
  logic signed [A_W-1:0] w_gnt_a;
  logic signed [B_W-1:0] w_gnt_b;
  logic                  w_res_valid;
  logic [ID_W-1:0]       w_res_id;
  logic signed [P_W-1:0] w_res_data;

  // Circular priority search starting at the round-robin pointer.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_req_ready = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_gnt_found && arb_en && !ap_rst &&
          req_valid[ID_W'((int'(r_rr_ptr) + j) % N_REQ)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = ID_W'((int'(r_rr_ptr) + j) % N_REQ);
      end
    end
    if (w_gnt_found) w_req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_accept = |(req_valid & w_req_ready);
  assign w_multi  = |(req_valid & (req_valid - N_REQ'(1)));
  assign w_gnt_a  = req_a[int'(w_gnt_idx)*A_W +: A_W];
  assign w_gnt_b  = req_b[int'(w_gnt_idx)*B_W +: B_W];

  // Advance the pointer past the requester just served.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
    end
  end

  // Outstanding operation count: +1 on accept, -1 on result, both cancel.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_res_valid})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Saturating count of enabled cycles with competing requesters.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_conflict <= '0;
    end else if (arb_en && w_multi && r_conflict != 16'hFFFF) begin
      r_conflict <= r_conflict + 16'd1;
    end
  end

  ptcalc_mul_pipe #(
    .LAT  (MUL_LAT),
    .A_W  (A_W),
    .B_W  (B_W),
    .ID_W (ID_W)
  ) u_mul_pipe (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_valid (w_accept),
    .i_id    (w_gnt_idx),
    .i_a     (w_gnt_a),
    .i_b     (w_gnt_b),
    .o_valid (w_res_valid),
    .o_id    (w_res_id),
    .o_data  (w_res_data)
  );

  assign req_ready    = w_req_ready;
  assign res_valid    = w_res_valid;
  assign res_id       = w_res_id;
  assign res_data     = w_res_data;
  assign inflight     = r_inflight;
  assign conflict_cnt = r_conflict;

endmodule

// File: tb/tb_ptcalc_mul_arb.sv
// Self-checking bench for ptcalc_mul_arb: a negedge scoreboard models grants,
// products, latency, inflight and conflict count; scenario tasks add their
// own targeted checks.
module tb_ptcalc_mul_arb;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int A_W = 21;
  localparam int B_W = 12;
  localparam int P_W = A_W + B_W;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic             arb_en = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*A_W-1:0] req_a = '0;
  logic [N*B_W-1:0] req_b = '0;
  wire  [N-1:0]     req_ready;
  wire              res_valid;
  wire  [P_W-1:0]   res_data;
  wire  [1:0]       res_id;
  wire  [1:0]       inflight;
  wire  [15:0]      conflict_cnt;

  ptcalc_mul_arb #(
    .N_REQ   (N),
    .MUL_LAT (LAT),
    .A_W     (A_W),
    .B_W     (B_W)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .arb_en       (arb_en),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_id       (res_id),
    .inflight     (inflight),
    .conflict_cnt (conflict_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerr    = 0;
  bit verbose = 1'b1;

  typedef struct {
    int     id;
    longint prod;
    int     due;
  } exp_t;
  exp_t sb[$];

  int             m_rr   = 0;
  int             m_infl = 0;
  int             m_conf = 0;
  int             m_last_id = 0;
  logic [P_W-1:0] m_last_data = '0;

  // Scoreboard: predicts grants from its own pointer, pushes expected
  // products on predicted accepts, pops them when their due cycle arrives.
  always @(negedge ap_clk) begin
    int g;
    int nv;
    logic [N-1:0] exp_rdy;
    logic signed [A_W-1:0] ta;
    logic signed [B_W-1:0] tbv;
    bit exp_v;
    exp_t e;
    if (ap_rst) begin
      nchecks++;
      if (req_ready !== '0) begin
        nerr++;
        $display("FAIL ready_in_reset: got %b need 0000", req_ready);
      end
      sb.delete();
      m_rr = 0; m_infl = 0; m_conf = 0; m_last_id = 0; m_last_data = '0;
    end else begin
      g = -1;
      if (arb_en)
        for (int j = 0; j < N; j++)
          if (g < 0 && req_valid[(m_rr + j) % N]) g = (m_rr + j) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      nchecks++;
      if (req_ready !== exp_rdy) begin
        nerr++;
        $display("FAIL grant: cyc %0d got %b need %b", cyc, req_ready, exp_rdy);
      end
      nchecks++;
      if (inflight !== 2'(m_infl)) begin
        nerr++;
        $display("FAIL inflight: cyc %0d got %0d need %0d", cyc, inflight, m_infl);
      end
      nchecks++;
      if (conflict_cnt !== 16'(m_conf)) begin
        nerr++;
        $display("FAIL conflict_cnt: cyc %0d got %0d need %0d", cyc, conflict_cnt, m_conf);
      end
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      nchecks++;
      if (res_valid !== exp_v) begin
        nerr++;
        $display("FAIL res_valid: cyc %0d got %b need %b", cyc, res_valid, exp_v);
      end
      if (exp_v) begin
        e = sb.pop_front();
        m_infl--;
        m_last_id   = e.id;
        m_last_data = P_W'(e.prod);
        if (verbose)
          $display("result cyc=%0d id=%0d data=%0d expect id=%0d data=%0d",
                   cyc, res_id, $signed(res_data), e.id, e.prod);
      end
      nchecks++;
      if (res_id !== 2'(m_last_id) || res_data !== m_last_data) begin
        nerr++;
        $display("FAIL res_id_data: cyc %0d got id %0d data %0d need id %0d data %0d",
                 cyc, res_id, $signed(res_data), m_last_id, $signed(m_last_data));
      end
      if (g >= 0) begin
        ta  = req_a[g*A_W +: A_W];
        tbv = req_b[g*B_W +: B_W];
        e.id   = g;
        e.prod = longint'(ta) * longint'(tbv);
        e.due  = cyc + LAT;
        sb.push_back(e);
        m_infl++;
        m_rr = (g + 1) % N;
        if (verbose)
          $display("accept cyc=%0d id=%0d a=%0d b=%0d", cyc, g, ta, tbv);
      end
      nv = $countones(req_valid);
      if (arb_en && nv > 1 && m_conf != 65535) m_conf++;
    end
  end

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    ap_rst = 1'b1;
    repeat (n) next_cycle();
    ap_rst = 1'b0;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  task automatic test_reset();
    req_valid = '0;
    arb_en = 1'b1;
    do_reset(3);
    @(negedge ap_clk);
    nchecks++;
    if (res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 ||
        inflight !== '0 || conflict_cnt !== '0 || req_ready !== '0) begin
      nerr++;
      $display("FAIL reset_values: got v%b d%0d id%0d inf%0d cc%0d rdy%b need all zero",
               res_valid, res_data, res_id, inflight, conflict_cnt, req_ready);
    end
    $display("reset released at cyc=%0d", cyc);
  endtask

  task automatic test_single();
    int t0;
    bit got;
    next_cycle();
    req_valid = 4'b0100;
    set_op(2, 1000, -3);
    @(negedge ap_clk);
    t0 = cyc;
    nchecks++;
    if (req_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL single_grant: got %b need 0100", req_ready);
    end
    next_cycle();
    req_valid = '0;
    @(negedge ap_clk);
    nchecks++;
    if (inflight !== 2'd1) begin
      nerr++;
      $display("FAIL single_inflight1: got %0d need 1", inflight);
    end
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      next_cycle();
      @(negedge ap_clk);
      if (res_valid) begin
        got = 1'b1;
        nchecks++;
        if (cyc - t0 != 3 || res_id !== 2'd2 || $signed(res_data) !== 33'sd0 - 33'sd3000) begin
          nerr++;
          $display("FAIL single_result: got lat %0d id %0d data %0d need lat 3 id 2 data -3000",
                   cyc - t0, res_id, $signed(res_data));
        end
      end
    end
    nchecks++;
    if (!got) begin
      nerr++;
      $display("FAIL single_timeout: got no result need one within 8 cycles");
    end
    next_cycle();
    @(negedge ap_clk);
    nchecks++;
    if (inflight !== 2'd0) begin
      nerr++;
      $display("FAIL single_inflight0: got %0d need 0", inflight);
    end
  endtask

  task automatic test_all4();
    int nres = 0;
    int first = 0;
    int last = 0;
    do_reset(2);
    arb_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k < 8) begin
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_op(i, (i + 1) * 1000 + k, k - 5);
      end else begin
        req_valid = '0;
      end
      @(negedge ap_clk);
      if (k < 8) begin
        nchecks++;
        if (req_ready !== 4'(1 << (k % 4))) begin
          nerr++;
          $display("FAIL all4_grant: step %0d got %b need %b", k, req_ready, 4'(1 << (k % 4)));
        end
      end
      if (k == 8) begin
        nchecks++;
        if (conflict_cnt !== 16'd8) begin
          nerr++;
          $display("FAIL all4_conflict: got %0d need 8", conflict_cnt);
        end
      end
      if (res_valid) begin
        nchecks++;
        if (res_id !== 2'(nres % 4)) begin
          nerr++;
          $display("FAIL all4_order: result %0d got id %0d need %0d", nres, res_id, nres % 4);
        end
        if (nres == 0) first = cyc;
        last = cyc;
        nres++;
      end
      next_cycle();
    end
    nchecks++;
    if (nres != 8 || last - first != 7) begin
      nerr++;
      $display("FAIL all4_stream: got %0d results over %0d cycles need 8 over 7", nres, last - first);
    end
  endtask

  task automatic test_extremes();
    longint got[$];
    longint e0 = 64'sd2147483648;
    longint e1 = -64'sd2147481600;
    arb_en = 1'b1;
    req_valid = 4'b0010;
    set_op(1, -(1 << 20), -(1 << 11));
    next_cycle();
    set_op(1, (1 << 20) - 1, -(1 << 11));
    next_cycle();
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      if (res_valid) got.push_back(longint'($signed(res_data)));
      next_cycle();
    end
    nchecks++;
    if (got.size() != 2) begin
      nerr++;
      $display("FAIL extremes_count: got %0d results need 2", got.size());
    end else begin
      nchecks++;
      if (got[0] != e0) begin
        nerr++;
        $display("FAIL extremes_pos: got %0d need %0d", got[0], e0);
      end
      nchecks++;
      if (got[1] != e1) begin
        nerr++;
        $display("FAIL extremes_neg: got %0d need %0d", got[1], e1);
      end
    end
  endtask

  task automatic test_arb_en();
    int nres = 0;
    arb_en = 1'b1;
    req_valid = 4'b1001;
    set_op(0, 12345, 67);
    set_op(3, -54321, -89);
    for (int k = 0; k < 12; k++) begin
      if (k == 2) arb_en = 1'b0;
      if (k == 6) req_valid = '0;
      @(negedge ap_clk);
      if (k >= 2 && k < 6) begin
        nchecks++;
        if (req_ready !== '0) begin
          nerr++;
          $display("FAIL arb_en_block: step %0d got %b need 0000", k, req_ready);
        end
      end
      if (res_valid) nres++;
      next_cycle();
    end
    @(negedge ap_clk);
    nchecks++;
    if (nres != 2 || inflight !== 2'd0) begin
      nerr++;
      $display("FAIL arb_en_drain: got %0d results inflight %0d need 2 results inflight 0",
               nres, inflight);
    end
    next_cycle();
    arb_en = 1'b1;
  endtask

  task automatic test_reset_inflight();
    arb_en = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 777, 55);
    repeat (3) next_cycle();
    req_valid = '0;
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      nchecks++;
      if (res_valid !== 1'b0) begin
        nerr++;
        $display("FAIL reset_discard: step %0d got res_valid 1 need 0", k);
      end
      next_cycle();
    end
    @(negedge ap_clk);
    nchecks++;
    if (res_data !== '0 || res_id !== '0 || inflight !== '0 || conflict_cnt !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got d%0d id%0d inf%0d cc%0d need all zero",
               res_data, res_id, inflight, conflict_cnt);
    end
    next_cycle();
    req_valid = 4'b1111;
    @(negedge ap_clk);
    nchecks++;
    if (req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL reset_next_grant: got %b need 0001", req_ready);
    end
    next_cycle();
    req_valid = '0;
    repeat (6) next_cycle();
  endtask

  task automatic test_saturate();
    arb_en = 1'b1;
    verbose = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, -1000 * (i + 1), 3 + i);
    req_valid = 4'b1111;
    repeat (65540) next_cycle();
    req_valid = '0;
    @(negedge ap_clk);
    nchecks++;
    if (conflict_cnt !== 16'hFFFF) begin
      nerr++;
      $display("FAIL conflict_saturate: got %h need ffff", conflict_cnt);
    end
    verbose = 1'b1;
    repeat (6) next_cycle();
    @(negedge ap_clk);
    nchecks++;
    if (conflict_cnt !== 16'hFFFF) begin
      nerr++;
      $display("FAIL conflict_hold: got %h need ffff", conflict_cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_extremes();
    test_arb_en();
    test_reset_inflight();
    test_saturate();
    nchecks++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_leftover: got %0d pending need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
